// File: rtl/wiener_pkg.sv
// Shared definitions for the Wiener-filter statistics path.
package wiener_pkg;

    localparam int WIENER_CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        THROTTLE = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/wiener_credit_counter.sv
// Up/down saturating credit counter; flags a decrement that arrives with no credit outstanding.
module wiener_credit_counter
    import wiener_pkg::*;
#(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         underflow
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Simultaneous inc and dec cancel; either direction holds at its rail.
    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (count_q != MAX_C) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                underflow = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/wiener_frame_scheduler.sv
// Cuts the pixel stream into fixed-size blocks, strobes block boundaries and
// bounds the number of blocks outstanding in the stats path.
module wiener_frame_scheduler
    import wiener_pkg::*;
#(
    parameter  int TOTAL_SAMPLES = 64,
    parameter  int MAX_INFLIGHT  = 2,
    localparam int IW            = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [WIENER_CNT_W-1:0] blocks_per_frame,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic                    block_done,
    output logic                    sample_en,
    output logic                    block_start,
    output logic                    block_end,
    output logic [WIENER_CNT_W-1:0] block_idx,
    output logic [IW-1:0]           inflight,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_overrun
);

    localparam int SW = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(TOTAL_SAMPLES - 1);
    localparam logic [IW-1:0] MAX_C       = IW'(MAX_INFLIGHT);

    sched_state_t            state_q, state_d;
    logic [WIENER_CNT_W-1:0] bpf_q, bpf_d;
    logic [WIENER_CNT_W-1:0] block_idx_q, block_idx_d;
    logic [SW-1:0]           sample_cnt_q, sample_cnt_d;
    logic                    err_q, err_d;
    logic                    frame_seen_q, frame_seen_d;

    logic          accept;
    logic          last_block;
    logic [IW-1:0] inflight_next;
    logic          underflow;

    assign pix_ready   = (state_q == STREAM);
    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == DONE);
    assign accept      = pix_valid & pix_ready;
    assign sample_en   = accept;
    assign block_start = accept & (sample_cnt_q == '0);
    assign block_end   = accept & (sample_cnt_q == LAST_SAMPLE);
    assign last_block  = (block_idx_q == bpf_q - 32'd1);

    wiener_credit_counter #(
        .MAX (MAX_INFLIGHT),
        .W   (IW)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (block_end),
        .dec        (block_done),
        .count      (inflight),
        .count_next (inflight_next),
        .underflow  (underflow)
    );

    // Stray block_done pulses only count as overruns once a frame has been started.
    always_comb begin
        state_d      = state_q;
        bpf_d        = bpf_q;
        block_idx_d  = block_idx_q;
        sample_cnt_d = sample_cnt_q;
        frame_seen_d = frame_seen_q;
        err_d        = err_q | (underflow & frame_seen_q);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    bpf_d        = blocks_per_frame;
                    block_idx_d  = '0;
                    sample_cnt_d = '0;
                    err_d        = 1'b0;
                    frame_seen_d = 1'b1;
                    state_d      = (blocks_per_frame == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
                if (block_end) begin
                    block_idx_d = block_idx_q + 32'd1;
                    if (last_block) begin
                        state_d = DRAIN;
                    end else if (inflight_next == MAX_C) begin
                        state_d = THROTTLE;
                    end
                end
            end
            THROTTLE: begin
                if (block_done) begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (inflight_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bpf_q        <= '0;
            block_idx_q  <= '0;
            sample_cnt_q <= '0;
            err_q        <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bpf_q        <= bpf_d;
            block_idx_q  <= block_idx_d;
            sample_cnt_q <= sample_cnt_d;
            err_q        <= err_d;
            frame_seen_q <= frame_seen_d;
        end
    end

    assign block_idx   = block_idx_q;
    assign err_overrun = err_q;

endmodule
